dma_result_packer: RTL and testbench
====================================

// Module: dma_result_packer
// PURPOSE
//  Return-path counterpart of the DMA demux. Gathers 25-bit results from 18 PE lanes and
//  serialises them onto one 32-bit DMA word stream: DMAport = {data[24:0], 2'b00, code[4:0]}.
//  The code mapping matches the demux: code = 17 - lane (code 0 <-> lane 17, code 17 <-> lane 0).
//  Each lane has a one-entry buffer, arbitration is round-robin over codes, and the output register has a valid/ready handshake.
// PARAMETERS
//  NUM_LANES  18  lane count, 2..32; code = NUM_LANES-1-lane
//  DATA_W     25  payload width; DATA_W + 2 + IDX_W must equal 32
//  IDX_W      5   code field width
//  CNT_W      16  width of word_count
// PORTS
//  clk         in   1                  single clock, all logic on rising edge
//  rst         in   1                  synchronous, active-high reset
//  lane_valid  in   NUM_LANES          lane i offers lane_data slice i
//  lane_data   in   NUM_LANES*DATA_W   lane i at [i*DATA_W +: DATA_W]
//  lane_ready  out  NUM_LANES          lane i buffer empty; handshake = valid & ready
//  DMAport     out  32                 packed word {data, 2'b00, code}
//  dma_valid   out  1                  DMAport holds a word
//  dma_ready   in   1                  DMA sink accepts when dma_valid & dma_ready
//  word_count  out  CNT_W              count of DMA handshakes; wraps modulo 2^CNT_W
//  idle        out  1                  no lane buffer full and dma_valid low
// BEHAVIOUR
//  Reset (rst high at an edge) clears the following:
//   - all buffer-full flags, dma_valid, DMAport, word_count
//   - the round-robin pointer, set to last_code = NUM_LANES-1
//  After reset: lane_ready = all ones, idle = 1.
//  Reset mid-operation discards buffered and in-flight words; no partial word is ever emitted.
//  Lane buffer:
//   - lane_ready[i] = ~full[i]; this is purely registered state and has no combinational path from dma_ready.
//   - A lane handshake at edge E0 stores the data and sets full[i].
//   - full[i] clears at the edge its word is moved into the output register.
//   - A lane cannot refill in the same cycle its buffer drains; lane_ready rises the cycle after the drain.
//  Output register load:
//   - The register loads when a candidate exists and the register is free.
//   - Free means (~dma_valid) | (dma_valid & dma_ready); a back-to-back stream is sustained with dma_ready high.
//   - Candidate = the first full lane scanning codes last_code+1, last_code+2, ... with wrap after NUM_LANES-1 to 0.
//   - On load: DMAport = {buf[lane], 2'b00, code}, dma_valid = 1, and last_code = code.
//  Latency: lane handshake at E0 -> dma_valid high after E1 when the output is free (2-cycle minimum).
//  Throughput: one word per cycle when several lanes are full and dma_ready stays high.
//  Backpressure (dma_valid & ~dma_ready):
//   - DMAport and dma_valid hold stable.
//   - No buffer drains and last_code holds.
//  Simultaneous events:
//   - A DMA handshake and a new load in the same edge: the count increments and the new word replaces the old.
//   - With no candidate, dma_valid drops.
//  word_count: +1 per DMA handshake; wraps from 2^CNT_W-1 to 0.
//  idle = ~|full & ~dma_valid, combinational from registers.
//  Reserved bits [6:5] always 0.
//  lane_data is ignored for lanes whose handshake does not occur.
// TESTING
//  T1 lane 17 valid once, data 25'h1ABCDEF, dma_ready=1
//     -> after 2 edges dma_valid=1 and DMAport=32'hD5E6F780; word_count=1 after the next edge.
//  T2 lane 0 valid once, data 25'h0000001 -> DMAport=32'h00000091 (code 5'b10001).
//  T3 all 18 lanes valid in one cycle, dma_ready=1
//     -> 18 consecutive words, codes 0,1,...,17, one per cycle.
//     -> then idle=1 and word_count=18.
//  T4 as T3 but dma_ready=0 for 5 cycles
//     -> DMAport frozen on code 0 and lane_ready=0 for all lanes except lane 17.
//     -> On release, codes 0..17 follow in order with no loss or duplication.
//  T5 lanes 17 and 16 held continuously valid, dma_ready=1
//     -> output codes alternate 0,1,0,1; neither lane starves.
//  T6 assert rst while 10 words are pending
//     -> next cycle dma_valid=0, lane_ready all ones, word_count=0.
//     -> A fresh single word then emits with code order restarting at code 0.

Source files
------------

// File: rtl/dma_result_packer.sv
// dma_result_packer: round-robin packing of per-lane results into a 32-bit DMA word stream
module dma_result_packer #(
  parameter int NUM_LANES = 18,
  parameter int DATA_W = 25,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        lane_valid,
  input  logic [NUM_LANES*DATA_W-1:0] lane_data,
  output logic [NUM_LANES-1:0]        lane_ready,
  output logic [31:0]                 DMAport,
  output logic                        dma_valid,
  input  logic                        dma_ready,
  output logic [CNT_W-1:0]            word_count,
  output logic                        idle
);
  logic [NUM_LANES-1:0] full;
  logic [DATA_W-1:0] buf_q [NUM_LANES];
  logic [IDX_W-1:0] last_code;
  logic [IDX_W-1:0] sel_code;
  logic found;
  logic free;
  int c;
  int sel_lane;
  always_comb begin
    found = 1'b0;
    sel_lane = 0;
    c = 0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      c = int'(last_code) + k;
      c = c >= NUM_LANES ? c - NUM_LANES : c;
      if (!found && full[NUM_LANES-1-c]) begin
        found = 1'b1;
        sel_lane = NUM_LANES - 1 - c;
      end
    end
  end
  assign sel_code = IDX_W'(NUM_LANES - 1 - sel_lane);
  assign free = ~dma_valid | dma_ready;
  assign lane_ready = ~full;
  assign idle = ~|full & ~dma_valid;
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_LANES; i++)
      if (lane_valid[i] && !full[i]) buf_q[i] <= lane_data[i*DATA_W +: DATA_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      dma_valid <= 1'b0;
      DMAport <= '0;
      word_count <= '0;
      last_code <= IDX_W'(NUM_LANES - 1);
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (lane_valid[i] && !full[i]) full[i] <= 1'b1;
      if (found && free) full[sel_lane] <= 1'b0;
      if (dma_valid && dma_ready) word_count <= word_count + 1'b1;
      if (free) dma_valid <= found;
      if (found && free) begin
        DMAport <= {buf_q[sel_lane], 2'b00, sel_code};
        last_code <= sel_code;
      end
    end
  end
endmodule

// File: tb/tb_dma_result_packer.sv
// tb_dma_result_packer: scoreboard-checked directed bench for dma_result_packer
module tb_dma_result_packer;
  logic clk;
  logic rst;
  logic [17:0] lane_valid;
  logic [18*25-1:0] lane_data;
  logic [17:0] lane_ready;
  logic [31:0] DMAport;
  logic dma_valid;
  logic dma_ready;
  logic [15:0] word_count;
  logic idle;
  int total;
  int bad;
  logic [31:0] q [$];
  dma_result_packer dut (
    .clk(clk),
    .rst(rst),
    .lane_valid(lane_valid),
    .lane_data(lane_data),
    .lane_ready(lane_ready),
    .DMAport(DMAport),
    .dma_valid(dma_valid),
    .dma_ready(dma_ready),
    .word_count(word_count),
    .idle(idle)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [24:0] dat(input int i);
    return 25'(i * 32'h000A5F3 + 32'h0123456);
  endfunction
  function automatic logic [31:0] word(input int i);
    return {dat(i), 2'b00, 5'(17 - i)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fill_data();
    for (int i = 0; i < 18; i++) lane_data[i*25 +: 25] = dat(i);
  endtask
  task automatic offer(input logic [17:0] v);
    lane_valid = v;
    step();
    lane_valid = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(idle), 32'd1);
    chk("sb_empty", 32'(q.size()), 32'd0);
  endtask
  always @(negedge clk)
    if (!rst && dma_valid && dma_ready) begin
      chk("dma_word", DMAport, q.size() != 0 ? q.pop_front() : 32'hxxxxxxxx);
      chk("reserved", 32'(DMAport[6:5]), 32'd0);
    end
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    lane_valid = '0;
    lane_data = '0;
    dma_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(lane_ready), 32'h3FFFF);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_valid", 32'(dma_valid), 32'd0);
    chk("rst_port", DMAport, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    step();
    fill_data();
    lane_data[17*25 +: 25] = 25'h1ABCDEF;
    q.push_back(32'hD5E6F780);
    offer(18'h20000);
    @(negedge clk);
    chk("t1_lat_early", 32'(dma_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(dma_valid), 32'd1);
    chk("t1_port", DMAport, 32'hD5E6F780);
    chk("t1_count_pre", 32'(word_count), 32'd0);
    @(negedge clk);
    chk("t1_count", 32'(word_count), 32'd1);
    chk("t1_idle", 32'(idle), 32'd1);
    step();
    lane_data[0 +: 25] = 25'h0000001;
    q.push_back(32'h00000091);
    offer(18'h00001);
    @(negedge clk);
    @(negedge clk);
    chk("t2_port", DMAport, 32'h00000091);
    wait_idle(10);
    chk("t2_count", 32'(word_count), 32'd2);
    step();
    do_reset();
    fill_data();
    for (int c = 0; c < 18; c++) q.push_back(word(17 - c));
    offer(18'h3FFFF);
    @(posedge clk);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("t3_stream", 32'(dma_valid), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("t3_idle", 32'(idle), 32'd1);
    chk("t3_count", 32'(word_count), 32'd18);
    chk("t3_sb", 32'(q.size()), 32'd0);
    step();
    do_reset();
    dma_ready = 1'b0;
    for (int c = 0; c < 18; c++) q.push_back(word(17 - c));
    offer(18'h3FFFF);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(dma_valid), 32'd1);
      chk("t4_hold_port", DMAport, word(17));
      chk("t4_ready", 32'(lane_ready), 32'h20000);
      @(posedge clk);
    end
    #1;
    dma_ready = 1'b1;
    wait_idle(40);
    chk("t4_count", 32'(word_count), 32'd18);
    step();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      q.push_back(word(17));
      q.push_back(word(16));
    end
    lane_valid = 18'h30000;
    repeat (8) step();
    lane_valid = '0;
    wait_idle(20);
    chk("t5_count", 32'(word_count), 32'd8);
    step();
    do_reset();
    dma_ready = 1'b0;
    offer(18'h003FF);
    step();
    step();
    dma_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("t6_valid", 32'(dma_valid), 32'd0);
    chk("t6_ready", 32'(lane_ready), 32'h3FFFF);
    chk("t6_count", 32'(word_count), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    step();
    q.push_back(word(12));
    q.push_back(word(7));
    offer(18'h01080);
    wait_idle(20);
    chk("t6_fresh_count", 32'(word_count), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
